wb_rr_arbiter: RTL and testbench

Round-robin Wishbone classic arbiter that shares one slave port (the gpio peripheral, or any single-cycle-ack Wishbone slave) between NM bus masters, e.g. the CPU data port and a test/debug master. It holds a grant for the whole bus cycle (m_cyc high) and muxes address, data and control to the slave. It routes ack and read data back to the owner. A watchdog terminates stalled cycles with an error pulse.

---
 rtl/wb_pkg.sv | 17 +
 rtl/rr_pick.sv | 35 +++
 rtl/wb_rr_arbiter.sv | 131 +++++++++++++
 tb/tb_wb_rr_arbiter.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared Wishbone arbiter definitions: bus widths, FSM state
// encoding and the round-robin pointer width helper.
package wb_pkg;

   localparam int WB_ADDR_W = 32;
   localparam int WB_DATA_W = 32;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   function automatic int ptr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: one-hot grant of the first
// requester at index >= ptr, wrapping. Ports: req, ptr -> gnt.
module rr_pick
   import wb_pkg::*;
#(
   parameter int NM = 2,
   parameter int PW = ptr_w(NM)
) (
   input  logic [NM-1:0] req,
   input  logic [PW-1:0] ptr,
   output logic [NM-1:0] gnt
);

   // Rank each master by its rotated distance from ptr; the
   // closest requester wins. Distances are unique, so gnt is
   // one-hot (or zero with no request).
   always_comb begin
      int best;
      int d;
      gnt  = '0;
      best = NM;
      d    = 0;
      for (int i = 0; i < NM; i++) begin
         d = i - int'(ptr);
         if (d < 0) d = d + NM;
         if (req[i] && d < best) best = d;
      end
      for (int i = 0; i < NM; i++) begin
         d = i - int'(ptr);
         if (d < 0) d = d + NM;
         if (req[i] && d == best) gnt[i] = 1'b1;
      end
   end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone classic arbiter with stall watchdog.
// Masters m_* (flattened NM x 32), slave s_*, status grant/busy.
module wb_rr_arbiter
   import wb_pkg::*;
#(
   parameter int NM      = 2,
   parameter int TIMEOUT = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NM-1:0]           m_cyc,
   input  logic [NM-1:0]           m_stb,
   input  logic [NM-1:0]           m_we,
   input  logic [NM*WB_ADDR_W-1:0] m_addr,
   input  logic [NM*WB_DATA_W-1:0] m_data_i,
   output logic [WB_DATA_W-1:0]    m_data_o,
   output logic [NM-1:0]           m_ack,
   output logic [NM-1:0]           m_err,
   output logic                    s_cyc,
   output logic                    s_stb,
   output logic                    s_we,
   output logic [WB_ADDR_W-1:0]    s_addr,
   output logic [WB_DATA_W-1:0]    s_data_o,
   input  logic [WB_DATA_W-1:0]    s_data_i,
   input  logic                    s_ack,
   output logic [NM-1:0]           grant,
   output logic                    busy
);

   localparam int PW = ptr_w(NM);
   localparam int TW = $clog2(TIMEOUT + 1);

   state_t          state, state_nx;
   logic [NM-1:0]   grant_nx, pick, err_nx;
   logic [PW-1:0]   ptr, ptr_nx, own_idx, own_inc;
   logic [TW-1:0]   timer, timer_nx;
   logic            sel_cyc, sel_stb, sel_we;
   logic [WB_ADDR_W-1:0] sel_addr;
   logic [WB_DATA_W-1:0] sel_data;
   logic            to_hit;

   rr_pick #(.NM(NM), .PW(PW)) u_pick (
      .req (m_cyc),
      .ptr (ptr),
      .gnt (pick)
   );

   always_comb begin
      sel_cyc  = 1'b0;
      sel_stb  = 1'b0;
      sel_we   = 1'b0;
      sel_addr = '0;
      sel_data = '0;
      own_idx  = '0;
      for (int i = 0; i < NM; i++) begin
         if (grant[i]) begin
            sel_cyc  = m_cyc[i];
            sel_stb  = m_stb[i];
            sel_we   = m_we[i];
            sel_addr = m_addr[WB_ADDR_W*i +: WB_ADDR_W];
            sel_data = m_data_i[WB_DATA_W*i +: WB_DATA_W];
            own_idx  = PW'(i);
         end
      end
   end

   assign busy     = (state == ST_GRANT);
   assign s_cyc    = busy & sel_cyc;
   assign s_stb    = busy & sel_stb;
   assign s_we     = busy & sel_we;
   assign s_addr   = busy ? sel_addr : '0;
   assign s_data_o = busy ? sel_data : '0;
   assign m_ack    = {NM{s_ack & busy}} & grant;
   assign m_data_o = s_data_i;

   assign own_inc = (own_idx == PW'(NM - 1)) ? '0
                                             : own_idx + PW'(1);

   // An ack in the last allowed cycle still completes the beat.
   assign to_hit = s_stb & ~s_ack
                 & (timer == TW'(TIMEOUT - 1));

   always_comb begin
      if (!busy || s_ack || !s_stb) timer_nx = '0;
      else                          timer_nx = timer + TW'(1);
   end

   always_comb begin
      state_nx = state;
      grant_nx = grant;
      ptr_nx   = ptr;
      err_nx   = '0;
      unique case (state)
         ST_IDLE: begin
            if (|m_cyc) begin
               state_nx = ST_GRANT;
               grant_nx = pick;
            end
         end
         ST_GRANT: begin
            if (!sel_cyc || to_hit) begin
               state_nx = ST_IDLE;
               grant_nx = '0;
               ptr_nx   = own_inc;
               if (sel_cyc) err_nx = grant;
            end
         end
         default: begin
            state_nx = ST_IDLE;
            grant_nx = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         grant <= '0;
         ptr   <= '0;
         timer <= '0;
         m_err <= '0;
      end else begin
         state <= state_nx;
         grant <= grant_nx;
         ptr   <= ptr_nx;
         timer <= timer_nx;
         m_err <= err_nx;
      end
   end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Scoreboard bench for wb_rr_arbiter: random multi-master rounds
// against a transaction-level round-robin model, plus directed cases.
module tb_wb_rr_arbiter;

   localparam int NM      = 3;
   localparam int TIMEOUT = 16;
   localparam int NOACK   = 255;

   logic            clk, rst;
   logic [NM-1:0]   m_cyc, m_stb, m_we;
   logic [NM*32-1:0] m_addr, m_data_i;
   logic [31:0]     m_data_o;
   logic [NM-1:0]   m_ack, m_err, grant;
   logic            s_cyc, s_stb, s_we, s_ack, busy;
   logic [31:0]     s_addr, s_data_o, s_data_i;

   wb_rr_arbiter #(.NM(NM), .TIMEOUT(TIMEOUT)) dut (
      .clk      (clk),
      .rst      (rst),
      .m_cyc    (m_cyc),
      .m_stb    (m_stb),
      .m_we     (m_we),
      .m_addr   (m_addr),
      .m_data_i (m_data_i),
      .m_data_o (m_data_o),
      .m_ack    (m_ack),
      .m_err    (m_err),
      .s_cyc    (s_cyc),
      .s_stb    (s_stb),
      .s_we     (s_we),
      .s_addr   (s_addr),
      .s_data_o (s_data_o),
      .s_data_i (s_data_i),
      .s_ack    (s_ack),
      .grant    (grant),
      .busy     (busy)
   );

   typedef struct {
      int          m;
      bit          err;
      bit          we;
      logic [31:0] addr;
      logic [31:0] data;
   } exp_t;

   exp_t sbq[$];
   int   checks = 0;
   int   failures = 0;
   int   viol = 0;
   int   ptr_m = 0;

   logic [31:0] b_addr [NM][2];
   logic [31:0] b_data [NM][2];
   bit          b_we   [NM][2];
   int          b_lat  [NM][2];
   int          nb [NM];
   int          pend [NM];
   int          beat [NM];
   bit          active [NM];
   bit          abort_m [NM];

   bit          sl_pend;
   int          sl_cnt;
   logic [31:0] sl_addr;
   logic [31:0] acc_addr, acc_data;
   bit          acc_we;

   function automatic logic [31:0] rd_fn(input logic [31:0] a);
      return {a[7:0], a[31:8]} ^ 32'hA5C3_0F96;
   endfunction

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", nm, got, exp);
      end
   endtask

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic drive(input int i, input bit on);
      m_cyc[i] = on;
      m_stb[i] = on;
      if (on) begin
         m_we[i]              = b_we[i][beat[i]];
         m_addr[32*i +: 32]   = b_addr[i][beat[i]];
         m_data_i[32*i +: 32] = b_data[i][beat[i]];
      end else begin
         m_we[i]              = 1'b0;
         m_addr[32*i +: 32]   = '0;
         m_data_i[32*i +: 32] = '0;
      end
   endtask

   // Masters and slave: sample mid-cycle, act just after the edge.
   initial begin
      logic [NM-1:0] c_ack, c_err, c_gnt;
      logic c_cyc, c_stb, c_we;
      logic [31:0] c_addr, c_dout;
      int own, lat;
      m_cyc = '0; m_stb = '0; m_we = '0;
      m_addr = '0; m_data_i = '0;
      s_ack = 1'b0; s_data_i = '0;
      sl_pend = 0; sl_cnt = 0; sl_addr = '0;
      acc_addr = '0; acc_data = '0; acc_we = 0;
      for (int i = 0; i < NM; i++) begin
         pend[i] = 0; beat[i] = 0;
         active[i] = 0; abort_m[i] = 0; nb[i] = 0;
      end
      forever begin
         @(negedge clk);
         c_ack = m_ack; c_err = m_err; c_gnt = grant;
         c_cyc = s_cyc; c_stb = s_stb; c_we = s_we;
         c_addr = s_addr; c_dout = s_data_o;
         @(posedge clk);
         #1;
         if (rst) begin
            for (int i = 0; i < NM; i++) begin
               active[i] = 0; pend[i] = 0; abort_m[i] = 0;
               drive(i, 0);
            end
            sl_pend = 0;
            s_ack = 1'b0;
         end else begin
            if (s_ack) begin
               s_ack = 1'b0;
            end else if (sl_pend) begin
               if (sl_cnt == 0) begin
                  s_ack = 1'b1;
                  s_data_i = rd_fn(sl_addr);
                  sl_pend = 0;
               end else begin
                  sl_cnt--;
               end
            end else if (c_cyc && c_stb) begin
               own = 0;
               for (int i = 0; i < NM; i++)
                  if (c_gnt[i]) own = i;
               lat = b_lat[own][beat[own]];
               acc_addr = c_addr; acc_data = c_dout; acc_we = c_we;
               if (lat == 0) begin
                  s_ack = 1'b1;
                  s_data_i = rd_fn(c_addr);
               end else if (lat != NOACK) begin
                  sl_pend = 1; sl_cnt = lat - 1; sl_addr = c_addr;
               end
            end
            for (int i = 0; i < NM; i++) begin
               if (active[i]) begin
                  if (c_err[i]) begin
                     active[i] = 0; pend[i] = 0; drive(i, 0);
                  end else if (c_ack[i]) begin
                     beat[i]++; pend[i]--;
                     if (pend[i] == 0) begin
                        active[i] = 0; drive(i, 0);
                     end else begin
                        drive(i, 1);
                     end
                  end else if (abort_m[i] && c_gnt[i]) begin
                     active[i] = 0; pend[i] = 0; abort_m[i] = 0;
                     drive(i, 0);
                  end
               end else if (pend[i] > 0) begin
                  active[i] = 1; beat[i] = 0; drive(i, 1);
               end
            end
         end
      end
   end

   // Monitor: every ack/err pops one expected terminal event.
   initial begin
      exp_t e;
      bit ok;
      forever begin
         @(negedge clk);
         if (!rst) begin
            for (int i = 0; i < NM; i++) begin
               if (m_ack[i] || m_err[i]) begin
                  checks++;
                  if (sbq.size() == 0) begin
                     failures++;
                     $display("FAIL sb_unexpected m=%0d ack=%b err=%b exp=none",
                              i, m_ack[i], m_err[i]);
                  end else begin
                     e = sbq.pop_front();
                     ok = (e.m == i) && (e.err == m_err[i])
                        && (e.err != m_ack[i]);
                     if (ok && !e.err) begin
                        if (e.we)
                           ok = acc_we && acc_addr == e.addr
                             && acc_data == e.data;
                        else
                           ok = !acc_we && m_data_o == rd_fn(e.addr);
                     end
                     if (!ok) begin
                        failures++;
                        $display("FAIL sb_event got m=%0d ack=%b err=%b d=%h a=%h exp m=%0d err=%b we=%b a=%h",
                                 i, m_ack[i], m_err[i], m_data_o, acc_addr,
                                 e.m, e.err, e.we, e.addr);
                     end
                  end
               end
            end
         end
      end
   end

   // Watchdog timing: err must land TIMEOUT cycles after the stall began.
   initial begin
      int ncyc, t0;
      bit pstb, pack;
      ncyc = 0; t0 = 0; pstb = 0; pack = 0;
      forever begin
         @(negedge clk);
         ncyc++;
         if (rst) begin
            pstb = 0; pack = 0;
         end else begin
            if (s_stb && (!pstb || pack)) t0 = ncyc;
            if (|m_err) begin
               checks++;
               if (ncyc - t0 != TIMEOUT) begin
                  failures++;
                  $display("FAIL err_timing got=%0d exp=%0d",
                           ncyc - t0, TIMEOUT);
               end
            end
            pstb = s_stb; pack = s_ack;
         end
      end
   end

   // Structural invariants, tallied and checked once at the end.
   initial begin
      logic [NM-1:0] pg;
      pg = '0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (!$onehot0(grant)) viol++;
            if (busy != (grant != '0)) viol++;
            if (pg != '0 && grant != '0 && grant != pg) viol++;
            if ((m_ack & ~grant) != '0) viol++;
            if (!busy && (s_cyc || s_stb)) viol++;
            pg = grant;
         end else begin
            pg = '0;
         end
      end
   end

   task automatic set1(input int i, input bit we, input logic [31:0] a,
                       input logic [31:0] d, input int lat);
      nb[i] = 1;
      b_we[i][0] = we; b_addr[i][0] = a;
      b_data[i][0] = d; b_lat[i][0] = lat;
   endtask

   task automatic plan_random(input logic [NM-1:0] mask);
      for (int i = 0; i < NM; i++) begin
         if (mask[i]) begin
            nb[i] = $urandom_range(1, 2);
            for (int b = 0; b < 2; b++) begin
               b_addr[i][b] = $urandom & 32'hFFFF_FFFC;
               b_data[i][b] = $urandom;
               b_we[i][b]   = 1'($urandom_range(0, 1));
               b_lat[i][b]  = ($urandom_range(0, 5) == 0)
                            ? NOACK : $urandom_range(0, 3);
            end
         end
      end
   endtask

   // Reference model: serve requesters in rotation order from ptr_m;
   // each contributes its beats, stopping at a stalled beat.
   task automatic launch(input logic [NM-1:0] mask, input bit push);
      int last, i;
      exp_t e;
      last = -1;
      if (push) begin
         for (int k = 0; k < NM; k++) begin
            i = (ptr_m + k) % NM;
            if (mask[i]) begin
               for (int b = 0; b < nb[i]; b++) begin
                  e.m = i; e.err = (b_lat[i][b] == NOACK);
                  e.we = b_we[i][b]; e.addr = b_addr[i][b];
                  e.data = b_data[i][b];
                  sbq.push_back(e);
                  if (e.err) break;
               end
               last = i;
            end
         end
         if (last >= 0) ptr_m = (last + 1) % NM;
      end
      @(negedge clk);
      for (int j = 0; j < NM; j++)
         if (mask[j]) pend[j] = nb[j];
   endtask

   task automatic wait_idle();
      int n;
      bit done;
      n = 0;
      forever begin
         @(negedge clk);
         done = !busy && !sl_pend && !s_ack;
         for (int i = 0; i < NM; i++)
            if (active[i] || pend[i] != 0) done = 0;
         if (done) break;
         n++;
         if (n > 600) begin
            checks++; failures++;
            $display("FAIL idle_wait got=busy exp=idle");
            break;
         end
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic wait_grant(input logic [NM-1:0] g, input string nm);
      int n;
      n = 0;
      while (grant !== g && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (grant !== g) begin
         checks++; failures++;
         $display("FAIL %s got=%b exp=%b", nm, grant, g);
      end
   endtask

   initial begin
      int  n;
      bit  saw_ack, saw_sack;
      logic [NM-1:0] mask;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_grant", 32'(grant), 0);
      chk("rst_busy",  32'(busy), 0);
      chk("rst_scyc",  32'({s_cyc, s_stb, s_we}), 0);
      chk("rst_sbus",  s_addr | s_data_o, 0);
      chk("rst_mresp", 32'({m_ack, m_err}), 0);
      rst = 1'b0;

      set1(0, 0, 32'h10, 0, 0);
      set1(1, 1, 32'h20, 32'hCAFE_F00D, 0);
      launch(3'b011, 1);
      wait_grant(3'b001, "sim_first");
      wait_grant(3'b000, "sim_release");
      n = 0;
      while (grant == '0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("sim_gap", n, 1);
      chk("sim_second", 32'(grant), 32'b010);
      wait_idle();

      set1(0, 0, 32'h4, 0, 0);
      launch(3'b001, 1);
      @(negedge clk);
      chk("lat_idle", 32'(grant), 0);
      @(negedge clk);
      chk("lat_grant", 32'(grant), 32'b001);
      chk("lat_saddr", s_addr, 32'h4);
      @(negedge clk);
      chk("lat_ack", 32'(m_ack), 32'b001);
      chk("lat_data", m_data_o, rd_fn(32'h4));
      wait_idle();

      set1(1, 0, 32'h44, 0, 1);
      abort_m[1] = 1;
      launch(3'b010, 0);
      ptr_m = 2;
      wait_grant(3'b010, "abort_grant");
      saw_ack = 0; saw_sack = 0;
      repeat (4) begin
         @(negedge clk);
         saw_ack  = saw_ack | (|m_ack);
         saw_sack = saw_sack | s_ack;
      end
      chk("abort_noack", 32'(saw_ack), 0);
      chk("abort_lateack", 32'(saw_sack), 1);
      wait_idle();
      set1(0, 0, 32'h100, 0, 0);
      set1(2, 1, 32'h200, 32'h1234_5678, 2);
      launch(3'b101, 1);
      wait_idle();

      set1(1, 0, 32'h300, 0, 0);
      launch(3'b010, 1);
      wait_idle();
      set1(2, 0, 32'h400, 0, NOACK);
      launch(3'b100, 0);
      wait_grant(3'b100, "rst_own");
      repeat (3) @(negedge clk);
      chk("rst_pre_stb", 32'(s_stb), 1);
      #2 rst = 1'b1;
      #1;
      chk("rst_mid_cyc", 32'(s_cyc), 0);
      chk("rst_mid_grant", 32'(grant), 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      ptr_m = 0;
      repeat (2) @(negedge clk);
      set1(1, 0, 32'h500, 0, 0);
      set1(2, 0, 32'h600, 0, 0);
      launch(3'b110, 1);
      wait_idle();

      set1(0, 1, 32'h700, 32'hDEAD_BEEF, NOACK);
      set1(1, 0, 32'h800, 0, 0);
      launch(3'b011, 1);
      wait_idle();

      for (int r = 0; r < 40; r++) begin
         mask = NM'($urandom_range(1, (1 << NM) - 1));
         plan_random(mask);
         launch(mask, 1);
         wait_idle();
      end

      chk("invariants", viol, 0);
      chk("sb_drained", sbq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
